// File: rtl/imem_arbiter.sv
// imem_arbiter: byte-serial memory sequencer shared between instruction fetch
// (IF) and the load/store unit (LS). One byte moves per cycle; 8/16/32-bit
// little-endian transfers are split or assembled here. Round-robin on ties.
module imem_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic [31:0] ls_rdata,
   output logic        ls_done,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
   typedef enum logic {PORT_IF, PORT_LS} port_t;

   state_t      state;
   port_t       port;        // port owning the current transfer
   port_t       last_grant;  // loser of the next tie
   logic        we_q;
   logic [1:0]  last_idx;    // index of the final byte (nbytes - 1)
   logic [1:0]  cnt;         // byte index within the transfer
   logic [31:0] wdata_q;
   logic [31:0] asm_q;       // read assembly register

   port_t       grant_port;
   logic        grant_valid;
   logic [31:0] g_addr;
   logic        g_we;
   logic [1:0]  g_last;
   logic [31:0] g_wdata;
   logic [31:0] asm_next;
   logic [1:0]  lane_next;
   logic [7:0]  wbyte_next;

   // Arbitration: single requester wins outright, a tie goes to the port not served last.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      grant_port = PORT_LS;
      if (if_req && ls_req)
         grant_port = (last_grant == PORT_LS) ? PORT_IF : PORT_LS;
      else if (if_req)
         grant_port = PORT_IF;
   end

   assign grant_valid = if_req | ls_req;

   // Attributes of the winning request; IF is always a 4-byte read.
   always_comb begin
      g_addr  = ls_addr;
      g_we    = ls_we;
      g_wdata = ls_wdata;
      case (ls_size)
         2'd0:    g_last = 2'd0;
         2'd1:    g_last = 2'd1;
         default: g_last = 2'd3;
      endcase
      if (grant_port == PORT_IF) begin
         g_addr  = if_addr;
         g_we    = 1'b0;
         g_wdata = 32'h0;
         g_last  = 2'd3;
      end
   end

   // Assembly register with the byte arriving this cycle merged into lane cnt.
   always_comb begin
      asm_next = asm_q;
      asm_next[{cnt, 3'b000} +: 8] = mem_rdata;
   end

   assign lane_next  = cnt + 2'd1;
   assign wbyte_next = wdata_q[{lane_next, 3'b000} +: 8];

   // Sequencer FSM; memory bus, done pulses and rdata are all registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         port       <= PORT_IF;
         last_grant <= PORT_LS;
         we_q       <= 1'b0;
         last_idx   <= 2'd0;
         cnt        <= 2'd0;
         wdata_q    <= 32'h0;
         asm_q      <= 32'h0;
         if_rdata   <= 32'h0;
         if_done    <= 1'b0;
         ls_rdata   <= 32'h0;
         ls_done    <= 1'b0;
         mem_addr   <= 32'h0;
         mem_we     <= 1'b0;
         mem_wdata  <= 8'h0;
         busy       <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  state      <= XFER;
                  port       <= grant_port;
                  last_grant <= grant_port;
                  we_q       <= g_we;
                  last_idx   <= g_last;
                  wdata_q    <= g_wdata;
                  cnt        <= 2'd0;
                  // Cleared so lanes beyond a short read come out as zero.
                  asm_q      <= 32'h0;
                  mem_addr   <= g_addr;
                  mem_we     <= g_we;
                  mem_wdata  <= g_we ? g_wdata[7:0] : 8'h0;
                  busy       <= 1'b1;
               end
            end
            XFER: begin
               if (!we_q)
                  asm_q <= asm_next;
               if (cnt == last_idx) begin
                  state     <= RESP;
                  cnt       <= 2'd0;
                  mem_addr  <= 32'h0;
                  mem_we    <= 1'b0;
                  mem_wdata <= 8'h0;
                  // rdata is loaded on entry to RESP so it is valid alongside done.
                  if (port == PORT_IF) begin
                     if_done  <= 1'b1;
                     if_rdata <= asm_next;
                  end else begin
                     ls_done <= 1'b1;
                     if (!we_q)
                        ls_rdata <= asm_next;
                  end
               end else begin
                  cnt       <= lane_next;
                  // 32-bit increment wraps 0xFFFFFFFF to 0 naturally.
                  mem_addr  <= mem_addr + 32'd1;
                  mem_wdata <= we_q ? wbyte_next : 8'h0;
               end
            end
            RESP: begin
               state   <= IDLE;
               if_done <= 1'b0;
               ls_done <= 1'b0;
               busy    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios plus concurrent random traffic on both
// ports, checked every cycle against a transaction-level model of the arbiter.
module tb_imem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        ls_req;
   logic        ls_we;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [31:0] ls_rdata;
   logic        ls_done;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;

   imem_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_size   (ls_size),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_rdata  (ls_rdata),
      .ls_done   (ls_done),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory seen by the DUT (256 bytes, aliased on the low address byte).
   logic [7:0] tb_mem [256];
   logic       pl_en;
   logic [7:0] pl_addr;
   logic [7:0] pl_data;

   always @(posedge clk) begin
      if (mem_we)
         tb_mem[mem_addr[7:0]] <= mem_wdata;
      if (pl_en)
         tb_mem[pl_addr] <= pl_data;
   end

   always_comb mem_rdata = tb_mem[mem_addr[7:0]];

   // ---------------- reference model ----------------
   // One entry per expected cycle after a grant; an empty queue means idle.
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wdata;
      logic        busy;
      logic        ifd;
      logic        lsd;
      logic        upd_if;
      logic        upd_ls;
      logic [31:0] rd;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  model_mem [256];
   logic [31:0] m_if_rd;
   logic [31:0] m_ls_rd;
   bit          m_last_ls;

   task automatic plan_txn();
      bit          use_if;
      logic [31:0] base;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      bit          we;
      int          n;
      exp_t        e;
      use_if    = if_req && (!ls_req || m_last_ls);
      m_last_ls = !use_if;
      if (use_if) begin
         base = if_addr; n = 4; we = 1'b0; wd = 32'h0;
      end else begin
         base = ls_addr; we = ls_we; wd = ls_wdata;
         n = (ls_size == 2'd0) ? 1 : (ls_size == 2'd1) ? 2 : 4;
      end
      rd = 32'h0;
      for (int j = 0; j < n; j++) begin
         a = base + 32'(j);
         if (!we)
            rd = rd | (32'(model_mem[a[7:0]]) << (8 * j));
         e       = '0;
         e.addr  = a;
         e.we    = we;
         e.wdata = we ? 8'(wd >> (8 * j)) : 8'h0;
         e.busy  = 1'b1;
         q.push_back(e);
      end
      e        = '0;
      e.busy   = 1'b1;
      e.ifd    = use_if;
      e.lsd    = !use_if;
      e.upd_if = use_if;
      e.upd_ls = !use_if && !we;
      e.rd     = rd;
      q.push_back(e);
   endtask

   // Per-cycle compare of every DUT output against the model.
   always @(negedge clk) begin : model_check
      exp_t e;
      bit   idle;
      if (pl_en)
         model_mem[pl_addr] = pl_data;
      if (!rst_n) begin
         q.delete();
         m_if_rd   = 32'h0;
         m_ls_rd   = 32'h0;
         m_last_ls = 1'b1;
      end else begin
         if (q.size() == 0) begin
            e    = '0;
            idle = 1'b1;
         end else begin
            e    = q.pop_front();
            idle = 1'b0;
         end
         if (e.upd_if) m_if_rd = e.rd;
         if (e.upd_ls) m_ls_rd = e.rd;
         if (e.we) model_mem[e.addr[7:0]] = e.wdata;
         check("bus", {23'h0, mem_addr, mem_we, mem_wdata}, {23'h0, e.addr, e.we, e.wdata});
         check("ctl", {61'h0, busy, if_done, ls_done}, {61'h0, e.busy, e.ifd, e.lsd});
         check("rdata", {if_rdata, ls_rdata}, {m_if_rd, m_ls_rd});
         if (idle && (if_req || ls_req))
            plan_txn();
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [31:0] rec_addr[$];
   logic [7:0]  rec_wdata[$];

   task automatic ls_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
      int k;
      bit got;
      ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
      rec_addr.delete(); rec_wdata.delete();
      got = 1'b0; k = 0; rd = 32'h0;
      while (!got && k < 200) begin
         @(posedge clk); #1; k++;
         if (busy && !if_done && !ls_done) begin
            rec_addr.push_back(mem_addr);
            rec_wdata.push_back(mem_wdata);
         end
         if (ls_done) begin
            got = 1'b1;
            rd  = ls_rdata;
         end
      end
      lat = k;
      check("ls_done_timeout", 64'(got), 64'd1);
      @(posedge clk); #1;
      ls_req = 1'b0;
   endtask

   task automatic if_op(input logic [31:0] a, output logic [31:0] rd, output int lat);
      int k;
      bit got;
      if_addr = a; if_req = 1'b1;
      rec_addr.delete();
      got = 1'b0; k = 0; rd = 32'h0;
      while (!got && k < 200) begin
         @(posedge clk); #1; k++;
         if (busy && !if_done && !ls_done)
            rec_addr.push_back(mem_addr);
         if (if_done) begin
            got = 1'b1;
            rd  = if_rdata;
         end
      end
      lat = k;
      check("if_done_timeout", 64'(got), 64'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   function automatic logic [7:0] init_byte(input int i);
      case (i)
         8'h10: return 8'h33;
         8'h11: return 8'h85;
         8'h12: return 8'hC5;
         8'h13: return 8'h00;
         8'h20: return 8'h11;
         8'h21: return 8'h22;
         8'h22: return 8'h33;
         8'h23: return 8'h44;
         8'h40, 8'h41, 8'h42, 8'h43: return 8'h99;
         8'hFE: return 8'hA5;
         8'hFF: return 8'h5A;
         8'h00: return 8'h3C;
         8'h01: return 8'hC3;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] rd;
      int          lat;
      int          if_dc[2];
      int          ls_dc[2];
      int          n_if;
      int          n_ls;
      logic [31:0] ls_rd_c;

      rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0;
      ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
      pl_en = 1'b0; pl_addr = 8'h0; pl_data = 8'h0;
      ls_rd_c = 32'h0;
      @(posedge clk); #1;

      // Preload both memories while the DUT is held in reset.
      for (int i = 0; i < 256; i++) begin
         pl_addr = 8'(i);
         pl_data = init_byte(i);
         pl_en   = 1'b1;
         @(posedge clk); #1;
      end
      pl_en = 1'b0;

      check("reset_bus", {23'h0, mem_addr, mem_we, mem_wdata}, 64'h0);
      check("reset_ctl", {61'h0, busy, if_done, ls_done}, 64'h0);
      check("reset_rdata", {if_rdata, ls_rdata}, 64'h0);
      rst_n = 1'b1;

      // Word fetch from 0x10.
      if_op(32'h10, rd, lat);
      check("fetch_rdata", 64'(rd), 64'h00C58533);
      check("fetch_latency", 64'(lat), 64'd5);
      check("fetch_nbytes", 64'(rec_addr.size()), 64'd4);
      for (int j = 0; j < 4 && j < rec_addr.size(); j++)
         check("fetch_addr", 64'(rec_addr[j]), 64'(32'h10 + 32'(j)));

      // Byte read, half write, then word read over the written bytes.
      ls_op(1'b0, 2'd0, 32'h23, 32'h0, rd, lat);
      check("byte_read", 64'(rd), 64'h44);
      check("byte_latency", 64'(lat), 64'd2);
      ls_op(1'b1, 2'd1, 32'h21, 32'h0000BEEF, rd, lat);
      check("write_keeps_rdata", 64'(ls_rdata), 64'h44);
      check("half_latency", 64'(lat), 64'd3);
      check("half_nbytes", 64'(rec_wdata.size()), 64'd2);
      if (rec_wdata.size() == 2) begin
         check("half_wdata0", 64'(rec_wdata[0]), 64'hEF);
         check("half_wdata1", 64'(rec_wdata[1]), 64'hBE);
         check("half_addr1", 64'(rec_addr[1]), 64'h22);
      end
      ls_op(1'b0, 2'd2, 32'h20, 32'h0, rd, lat);
      check("word_after_store", 64'(rd), 64'h44BEEF11);

      // Word read across the top of the address space.
      ls_op(1'b0, 2'd3, 32'hFFFFFFFE, 32'h0, rd, lat);
      check("wrap_rdata", 64'(rd), 64'hC33C5AA5);
      check("wrap_nbytes", 64'(rec_addr.size()), 64'd4);
      if (rec_addr.size() == 4) begin
         check("wrap_addr1", 64'(rec_addr[1]), 64'hFFFFFFFF);
         check("wrap_addr2", 64'(rec_addr[2]), 64'h0);
         check("wrap_addr3", 64'(rec_addr[3]), 64'h1);
      end

      // Reset after the second byte of a word write has been strobed.
      ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h40; ls_wdata = 32'hA1B2C3D4; ls_req = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_bus", {23'h0, mem_addr, mem_we, mem_wdata}, 64'h0);
      check("abort_ctl", {61'h0, busy, if_done, ls_done}, 64'h0);
      check("abort_rdata", {if_rdata, ls_rdata}, 64'h0);
      check("abort_partial", 64'({tb_mem[8'h43], tb_mem[8'h42], tb_mem[8'h41], tb_mem[8'h40]}),
            64'h9999C3D4);

      // Contention from reset release: IF, LS, IF, LS.
      ls_req = 1'b0;
      if_addr = 32'h10; if_req = 1'b1;
      ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h13; ls_req = 1'b1;
      if_dc = '{-1, -1}; ls_dc = '{-1, -1}; n_if = 0; n_ls = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         @(posedge clk); #1;
         if (if_done && n_if < 2) begin if_dc[n_if] = c; n_if++; end
         if (ls_done && n_ls < 2) begin ls_dc[n_ls] = c; n_ls++; ls_rd_c = ls_rdata; end
      end
      if_req = 1'b0; ls_req = 1'b0;
      check("cont_if_done0", 64'(if_dc[0]), 64'd5);
      check("cont_ls_done0", 64'(ls_dc[0]), 64'd8);
      check("cont_if_done1", 64'(if_dc[1]), 64'd14);
      check("cont_ls_done1", 64'(ls_dc[1]), 64'd17);
      check("cont_ls_rdata", 64'(ls_rd_c), 64'h0);

      // Concurrent random traffic from both ports.
      fork
         begin
            logic [31:0] r_rd;
            int          r_lat;
            for (int t = 0; t < 40; t++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               if_op($urandom, r_rd, r_lat);
            end
         end
         begin
            logic [31:0] r_rd;
            int          r_lat;
            for (int t = 0; t < 40; t++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               ls_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                     r_rd, r_lat);
            end
         end
      join

      repeat (4) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
